// File: rtl/relu_pool.sv
// ReLU followed by 2x2 stride-2 max pooling over a word-addressed feature map.
// Each output takes six read cycles plus one write cycle.

module relu_pool #(
  parameter int unsigned IN_DIM  = 26,
  parameter logic [31:0] RD_BASE = 32'h0000_0000,
  parameter logic [31:0] WR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  output logic        R_req,
  output logic [31:0] R_addr,
  input  logic [31:0] R_data,
  output logic [3:0]  W_req,
  output logic [31:0] W_addr,
  output logic [31:0] W_data,
  output logic        done
);

  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned IdxW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OUT_DIM - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [31:0]     max_q, max_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [3:0]      w_req_q, w_req_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [31:0]     w_data_q, w_data_d;
  logic            done_q, done_d;

  logic [31:0] relu_data, win_row, win_col, win_addr, out_addr;
  logic        last_out;

  assign relu_data = R_data[31] ? 32'h0 : R_data;
  assign last_out  = (ox_q == LastIdx) && (oy_q == LastIdx);

  // Window order follows cnt: bit 1 selects the row offset, bit 0 the column offset.
  assign win_row  = (32'(oy_q) << 1) + 32'(cnt_q[1]);
  assign win_col  = (32'(ox_q) << 1) + 32'(cnt_q[0]);
  assign win_addr = RD_BASE + ((win_row * IN_DIM + win_col) << 2);
  assign out_addr = WR_BASE + ((32'(oy_q) * OUT_DIM + 32'(ox_q)) << 2);

  always_comb begin
    state_d  = state_q;
    cnt_d    = 3'd0;
    ox_d     = ox_q;
    oy_d     = oy_q;
    max_d    = max_q;
    r_addr_d = r_addr_q;
    case (state_q)
      StIdle: begin
        if (ready) state_d = StRead;
      end
      StRead: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < 3'd4) r_addr_d = win_addr;
        // Read data lags its address by two counts.
        if (cnt_q == 3'd2) begin
          max_d = relu_data;
        end else if (cnt_q >= 3'd3 && $signed(relu_data) > $signed(max_q)) begin
          max_d = relu_data;
        end
        if (cnt_q == 3'd5) begin
          state_d = StWrite;
          cnt_d   = 3'd0;
        end
      end
      StWrite: begin
        if (last_out) begin
          state_d = StDone;
          ox_d    = '0;
          oy_d    = '0;
        end else begin
          state_d = StRead;
          if (ox_q == LastIdx) begin
            ox_d = '0;
            oy_d = oy_q + IdxW'(1);
          end else begin
            ox_d = ox_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    w_req_d  = 4'h0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (state_q == StWrite) begin
      w_req_d  = 4'hF;
      w_addr_d = out_addr;
      w_data_d = max_q;
    end
  end

  assign done_d = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      ox_q     <= '0;
      oy_q     <= '0;
      max_q    <= 32'h0;
      r_addr_q <= 32'h0;
      w_req_q  <= 4'h0;
      w_addr_q <= 32'h0;
      w_data_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      max_q    <= max_d;
      r_addr_q <= r_addr_d;
      w_req_q  <= w_req_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      done_q   <= done_d;
    end
  end

  assign R_req  = (state_q == StRead);
  assign R_addr = r_addr_q;
  assign W_req  = w_req_q;
  assign W_addr = w_addr_q;
  assign W_data = w_data_q;
  assign done   = done_q;

endmodule

// File: tb/tb_relu_pool.sv
// Self-checking bench for relu_pool: memory responder, write monitor and a
// window-max reference model over the stored map.

module tb_relu_pool;

  localparam int unsigned IN_DIM  = 26;
  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned NPIX    = IN_DIM * IN_DIM;
  localparam int unsigned NOUT    = OUT_DIM * OUT_DIM;
  localparam logic [31:0] RD_BASE = 32'h0000_1000;
  localparam logic [31:0] WR_BASE = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        R_req;
  logic [31:0] R_addr;
  logic [31:0] R_data;
  logic [3:0]  W_req;
  logic [31:0] W_addr;
  logic [31:0] W_data;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mem [NPIX];
  logic [31:0] rd_off;
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  wr_q [$];
  int          wc_q [$];

  relu_pool #(
    .IN_DIM (IN_DIM),
    .RD_BASE(RD_BASE),
    .WR_BASE(WR_BASE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .R_req (R_req),
    .R_addr(R_addr),
    .R_data(R_data),
    .W_req (W_req),
    .W_addr(W_addr),
    .W_data(W_data),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns the addressed word one cycle after the address.
  assign rd_off = R_addr - RD_BASE;
  always @(posedge clk) begin
    if (rd_off[1:0] == 2'b00 && (rd_off >> 2) < NPIX) R_data <= mem[rd_off >> 2];
    else R_data <= 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (W_req !== 4'h0) begin
      wa_q.push_back(W_addr);
      wd_q.push_back(W_data);
      wr_q.push_back(W_req);
      wc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
    wr_q.delete();
    wc_q.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pooled value of output o: the largest window value, floored at zero.
  function automatic logic [31:0] ref_out(int o);
    int ox, oy;
    logic signed [31:0] best, v;
    ox = o % OUT_DIM;
    oy = o / OUT_DIM;
    best = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = mem[(2 * oy + dy) * IN_DIM + 2 * ox + dx];
        if (v > best) best = v;
      end
    return best;
  endfunction

  task automatic run_full(output bit timed_out, output int ready_cyc, output int done_cyc);
    clear_writes();
    tick();
    ready = 1'b1;
    ready_cyc = cyc;
    tick();
    ready = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 1500; i++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    timed_out = (done_cyc < 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({R_req, R_addr, W_req, W_addr, W_data, done} !== 70'h0) begin
      n_err++;
      $display("FAIL reset: got R_req=%b R_addr=%h W_req=%h W_addr=%h W_data=%h done=%b, want all 0",
               R_req, R_addr, W_req, W_addr, W_data, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if ({R_req, W_req, done} !== 6'h0) begin
        n_err++;
        $display("FAIL idle[%0d]: got R_req=%b W_req=%h done=%b, want 0 0 0", i, R_req, W_req, done);
      end
    end
  endtask

  task automatic test_rst_priority();
    do_reset();
    tick();
    rst = 1'b1;
    ready = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (R_req !== 1'b0) begin
        n_err++;
        $display("FAIL rst_priority[%0d]: got R_req=%b, want 0", i, R_req);
      end
      tick();
    end
  endtask

  task automatic test_ramp();
    bit to;
    int rc, dc;
    do_reset();
    for (int i = 0; i < NPIX; i++) mem[i] = i;
    run_full(to, rc, dc);
    n_vec++;
    if (to || wa_q.size() != NOUT) begin
      n_err++;
      $display("FAIL ramp_count: got %0d writes timeout=%0d, want %0d", wa_q.size(), to, NOUT);
    end
    for (int i = 0; i < wa_q.size() && i < NOUT; i++) begin
      n_vec++;
      if ({wr_q[i], wa_q[i], wd_q[i]} !== {4'hF, WR_BASE + 32'(i * 4), ref_out(i)}) begin
        n_err++;
        $display("FAIL ramp_write[%0d]: got req=%h addr=%h data=%h, want req=f addr=%h data=%h",
                 i, wr_q[i], wa_q[i], wd_q[i], WR_BASE + 32'(i * 4), ref_out(i));
      end
    end
    if (wd_q.size() > 0) begin
      n_vec++;
      if (wa_q[0] !== WR_BASE || wd_q[0] !== 32'd27) begin
        n_err++;
        $display("FAIL ramp_first: got addr=%h data=%0d, want addr=%h data=27", wa_q[0], wd_q[0], WR_BASE);
      end
      n_vec++;
      if (wa_q[$] !== WR_BASE + 32'h2A0 || wd_q[$] !== 32'd675) begin
        n_err++;
        $display("FAIL ramp_last: got addr=%h data=%0d, want addr=%h data=675",
                 wa_q[$], wd_q[$], WR_BASE + 32'h2A0);
      end
    end
  endtask

  task automatic test_all_negative();
    bit to;
    int rc, dc;
    do_reset();
    for (int i = 0; i < NPIX; i++) mem[i] = 32'hFFFF_0000;
    run_full(to, rc, dc);
    n_vec++;
    if (to || wa_q.size() != NOUT) begin
      n_err++;
      $display("FAIL neg_count: got %0d writes timeout=%0d, want %0d", wa_q.size(), to, NOUT);
    end
    for (int i = 0; i < wd_q.size(); i++) begin
      n_vec++;
      if (wd_q[i] !== 32'h0) begin
        n_err++;
        $display("FAIL neg_data[%0d]: got %h, want 00000000", i, wd_q[i]);
      end
    end
  endtask

  task automatic test_signed_window();
    bit to;
    int rc, dc;
    do_reset();
    fill_random();
    mem[0]  = 32'hFFFF_FFFB;
    mem[1]  = 32'h0000_0003;
    mem[26] = 32'h7FFF_FFFF;
    mem[27] = 32'hFFFF_FFFF;
    mem[2]  = 32'hFFFF_FFFB;
    mem[3]  = 32'hFFFF_FFFF;
    mem[28] = 32'hFFFF_FFF9;
    mem[29] = 32'hFFFF_FFFE;
    run_full(to, rc, dc);
    n_vec++;
    if (to || wd_q.size() != NOUT) begin
      n_err++;
      $display("FAIL signed_count: got %0d writes timeout=%0d, want %0d", wd_q.size(), to, NOUT);
    end
    if (wd_q.size() >= 2) begin
      n_vec++;
      if (wd_q[0] !== 32'h7FFF_FFFF) begin
        n_err++;
        $display("FAIL signed_win0: got %h, want 7fffffff", wd_q[0]);
      end
      n_vec++;
      if (wd_q[1] !== 32'h0) begin
        n_err++;
        $display("FAIL signed_win1: got %h, want 00000000", wd_q[1]);
      end
    end
    for (int i = 2; i < wd_q.size() && i < NOUT; i++) begin
      n_vec++;
      if (wd_q[i] !== ref_out(i)) begin
        n_err++;
        $display("FAIL signed_data[%0d]: got %h, want %h", i, wd_q[i], ref_out(i));
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int rc, dc;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      fill_random();
      run_full(to, rc, dc);
      n_vec++;
      if (to || wa_q.size() != NOUT) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d writes timeout=%0d, want %0d", r, wa_q.size(), to, NOUT);
      end
      for (int i = 0; i < wa_q.size() && i < NOUT; i++) begin
        n_vec++;
        if ({wr_q[i], wa_q[i], wd_q[i]} !== {4'hF, WR_BASE + 32'(i * 4), ref_out(i)}) begin
          n_err++;
          $display("FAIL rand%0d_write[%0d]: got req=%h addr=%h data=%h, want req=f addr=%h data=%h",
                   r, i, wr_q[i], wa_q[i], wd_q[i], WR_BASE + 32'(i * 4), ref_out(i));
        end
      end
    end
  endtask

  task automatic test_timing();
    bit to;
    int rc, dc;
    do_reset();
    fill_random();
    run_full(to, rc, dc);
    n_vec++;
    if (to || wc_q.size() != NOUT) begin
      n_err++;
      $display("FAIL timing_count: got %0d pulses timeout=%0d, want %0d", wc_q.size(), to, NOUT);
    end
    if (wc_q.size() > 0) begin
      n_vec++;
      if (wc_q[0] != rc + 8) begin
        n_err++;
        $display("FAIL timing_first: got pulse %0d cycles after ready, want 8", wc_q[0] - rc);
      end
      n_vec++;
      if (dc != wc_q[$] + 1) begin
        n_err++;
        $display("FAIL timing_done: got done %0d cycles after last pulse, want 1", dc - wc_q[$]);
      end
    end
    for (int i = 1; i < wc_q.size(); i++) begin
      n_vec++;
      if (wc_q[i] - wc_q[i-1] != 7) begin
        n_err++;
        $display("FAIL timing_gap[%0d]: got %0d, want 7", i, wc_q[i] - wc_q[i-1]);
      end
    end
    clear_writes();
    for (int i = 0; i < 50; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      n_vec++;
      if ({done, R_req, W_req} !== 6'b100000) begin
        n_err++;
        $display("FAIL timing_hold[%0d]: got done=%b R_req=%b W_req=%h, want 1 0 0", i, done, R_req, W_req);
      end
    end
    ready = 1'b0;
    n_vec++;
    if (wa_q.size() != 0) begin
      n_err++;
      $display("FAIL timing_restart: got %0d writes after done, want 0", wa_q.size());
    end
  endtask

  task automatic test_abort();
    bit to;
    int rc, dc;
    bit hit;
    do_reset();
    fill_random();
    clear_writes();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (wa_q.size() >= 50) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL abort_reach: got %0d writes within budget, want 50", wa_q.size());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({R_req, R_addr, W_req, W_addr, W_data, done} !== 70'h0) begin
      n_err++;
      $display("FAIL abort_clear: got R_req=%b R_addr=%h W_req=%h W_addr=%h W_data=%h done=%b, want all 0",
               R_req, R_addr, W_req, W_addr, W_data, done);
    end
    clear_writes();
    for (int i = 0; i < 40; i++) tick();
    n_vec++;
    if (wa_q.size() != 0 || R_req !== 1'b0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d writes R_req=%b, want 0 writes R_req=0", wa_q.size(), R_req);
    end
    run_full(to, rc, dc);
    n_vec++;
    if (to || wa_q.size() != NOUT) begin
      n_err++;
      $display("FAIL abort_rerun_count: got %0d writes timeout=%0d, want %0d", wa_q.size(), to, NOUT);
    end
    for (int i = 0; i < wa_q.size() && i < NOUT; i++) begin
      n_vec++;
      if ({wa_q[i], wd_q[i]} !== {WR_BASE + 32'(i * 4), ref_out(i)}) begin
        n_err++;
        $display("FAIL abort_rerun[%0d]: got addr=%h data=%h, want addr=%h data=%h",
                 i, wa_q[i], wd_q[i], WR_BASE + 32'(i * 4), ref_out(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_rst_priority();
    test_ramp();
    test_all_negative();
    test_signed_window();
    test_random();
    test_timing();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
